// File: rtl/hazard_unit_pkg.sv
// Shared core encodings for the pipeline hazard logic and the datapath muxes.
package hazard_unit_pkg;

    // Select encodings for the Execute operand 3:1 muxes. 2'b11 is never driven.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Result source of an instruction.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    // Shadow of the ID/EX register: only the fields hazard detection needs.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic [1:0] result_src;
    } stage_e_t;

    // Shadow of EX/MEM and MEM/WB: destination and write enable only.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } stage_mw_t;

    // MEM has priority over WB because it holds the younger write.
    // x0 is hardwired to zero, so it is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m,
                                           input logic       rw_m,
                                           input logic [4:0] rd_w,
                                           input logic       rw_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != 5'd0 && rs == rd_m && rw_m)
            sel = FWD_MEM;
        else if (rs != 5'd0 && rs == rd_w && rw_w)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: loads a zero bubble on request, clears on reset.
module hazard_stage_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q;
    logic [W-1:0] stage_d;

    // Bubble replaces the incoming instruction with an all-zero no-op.
    always_comb begin
        stage_d = d_i;
        if (bubble_i)
            stage_d = '0;
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    assign q_o = stage_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// plus saturating event counters for stall and flush cycles.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic [1:0]  ResultSrcD,
    input  logic        PCSrcE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    stage_e_t  e_d, e_q;
    stage_mw_t m_d, m_q;
    stage_mw_t w_q;
    logic      lu_stall;
    logic      flush_e;

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Decode fields captured into the E shadow.
    always_comb begin
        e_d            = '0;
        e_d.rs1        = Rs1D;
        e_d.rs2        = Rs2D;
        e_d.rd         = RdD;
        e_d.reg_write  = RegWriteD;
        e_d.result_src = ResultSrcD;
    end

    // M always takes what E held; W follows M in the stage instance below.
    always_comb begin
        m_d           = '0;
        m_d.rd        = e_q.rd;
        m_d.reg_write = e_q.reg_write;
    end

    hazard_stage_reg #(.W($bits(stage_e_t))) u_stage_e (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (flush_e),
        .d_i      (e_d),
        .q_o      (e_q)
    );

    hazard_stage_reg #(.W($bits(stage_mw_t))) u_stage_m (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (m_d),
        .q_o      (m_q)
    );

    hazard_stage_reg #(.W($bits(stage_mw_t))) u_stage_w (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (m_q),
        .q_o      (w_q)
    );

    // Stall only on a real load into a nonzero register that Decode reads;
    // a taken branch squashes the consumer anyway, so the flush wins.
    always_comb begin
        lu_stall = (e_q.result_src == RES_LOAD) && (e_q.rd != 5'd0) &&
                   ((e_q.rd == Rs1D) || (e_q.rd == Rs2D)) && !PCSrcE;
        flush_e  = lu_stall || PCSrcE;
    end

    // Forward selects are combinational from registered shadow state.
    always_comb begin
        ForwardAE = fwd_sel(e_q.rs1, m_q.rd, m_q.reg_write, w_q.rd, w_q.reg_write);
        ForwardBE = fwd_sel(e_q.rs2, m_q.rd, m_q.reg_write, w_q.rd, w_q.reg_write);
        StallF    = lu_stall;
        StallD    = lu_stall;
        FlushD    = PCSrcE;
        FlushE    = flush_e;
    end

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (lu_stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (PCSrcE && flush_cnt_q != 32'hFFFF_FFFF)
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a per-cycle vector table plus reset sequences.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        PCSrcE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    always #5 clk = ~clk;

    // One row = Decode inputs for a cycle and the outputs expected in that
    // cycle (counters as seen before the closing clock edge).
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
        logic        pc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        stl;
        logic        fd;
        logic        fe;
        logic [31:0] sc;
        logic [31:0] fc;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] src, input logic pc);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = src; PCSrcE = pc;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic stl, input logic fd, input logic fe,
                           input logic [31:0] sc, input logic [31:0] fc);
        chk({tag, ".ForwardAE"},  32'(ForwardAE), 32'(fa));
        chk({tag, ".ForwardBE"},  32'(ForwardBE), 32'(fb));
        chk({tag, ".StallF"},     32'(StallF),    32'(stl));
        chk({tag, ".StallD"},     32'(StallD),    32'(stl));
        chk({tag, ".FlushD"},     32'(FlushD),    32'(fd));
        chk({tag, ".FlushE"},     32'(FlushE),    32'(fe));
        chk({tag, ".StallCount"}, StallCount,     sc);
        chk({tag, ".FlushCount"}, FlushCount,     fc);
    endtask

    initial begin
        //            rs1    rs2    rd     rw    src    pc    fa     fb     stl   fd    fe    sc     fc
        vec[0]  = '{5'd1,  5'd2,  5'd5,  1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // add x5,x1,x2
        vec[1]  = '{5'd5,  5'd1,  5'd6,  1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // sub x6,x5,x1
        vec[2]  = '{5'd5,  5'd9,  5'd5,  1'b1, 2'd0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // sub in E: MEM fwd A
        vec[3]  = '{5'd5,  5'd0,  5'd5,  1'b1, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // or in E: WB fwd A
        vec[4]  = '{5'd0,  5'd5,  5'd12, 1'b1, 2'd0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // addi in E: MEM fwd A
        vec[5]  = '{5'd1,  5'd0,  5'd7,  1'b1, 2'd1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}; // M and W both x5: MEM wins on B
        vec[6]  = '{5'd2,  5'd7,  5'd13, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0}; // lw x7 in E, Rs2D=7: stall
        vec[7]  = '{5'd2,  5'd7,  5'd13, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0}; // bubble in E, stall gone
        vec[8]  = '{5'd3,  5'd4,  5'd0,  1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0}; // consumer in E: WB fwd B
        vec[9]  = '{5'd13, 5'd1,  5'd14, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd0}; // branch taken
        vec[10] = '{5'd14, 5'd0,  5'd15, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1}; // E is bubble
        vec[11] = '{5'd1,  5'd0,  5'd9,  1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1}; // flushed x14 write never reaches M
        vec[12] = '{5'd9,  5'd0,  5'd16, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd1}; // load-use + branch: flush wins
        vec[13] = '{5'd1,  5'd0,  5'd0,  1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2}; // lw x0
        vec[14] = '{5'd0,  5'd0,  5'd17, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2}; // use x0: no stall
        vec[15] = '{5'd0,  5'd0,  5'd0,  1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2}; // x0 in M: no forward

        // Reset with hazardous-looking Decode inputs: everything stays quiet.
        rst = 1'b1;
        drive(5'd7, 5'd7, 5'd7, 1'b1, 2'd1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        #2;
        chk_all("post_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].rw, vec[i].src, vec[i].pc);
            #2;
            chk_all($sformatf("vec%0d", i), vec[i].fa, vec[i].fb, vec[i].stl,
                    vec[i].fd, vec[i].fe, vec[i].sc, vec[i].fc);
        end

        // Reset asserted in the middle of a load-use stall (consumer via Rs1D).
        @(negedge clk);
        drive(5'd1, 5'd0, 5'd7, 1'b1, 2'd1, 1'b0);   // lw x7
        @(negedge clk);
        drive(5'd7, 5'd0, 5'd18, 1'b1, 2'd0, 1'b0);  // reads x7 as rs1
        #2;
        chk("mid.StallD_before", 32'(StallD), 32'd1);
        chk("mid.FlushE_before", 32'(FlushE), 32'd1);
        chk("mid.StallCount_before", StallCount, 32'd1);
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_all("after_rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        #2;
        chk_all("after_rst2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
